bkm_lut_seq_ctrl: RTL

//  Iteration sequencer for the BKM FPU datapath.
//  - On start, steps the lut_decoder index n through 0..N_ITER-1.
//  - For each n, waits the decoder pipeline latency, then issues a step strobe
//    to the X/Y/u/v update datapath with valid/ready backpressure.
//  - Pulses done after the last iteration.
//  - Sits between the FPU top-level control and lut_decoder/BKM iteration stage.

---
 rtl/bkm_pkg.sv | 26 ++
 rtl/bkm_lat_timer.sv | 33 +++
 rtl/bkm_lut_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM iteration sequencer.
//  - state_t  : sequencer FSM state encoding (exposed on the debug port)
//  - MODE_*   : BKM mode codes carried on lut_mode
//  - FMT_*    : 2-bit operand format codes carried on lut_format
//  - STALL_W  : width of the saturating stall counter
package bkm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic MODE_EXP = 1'b0;
  localparam logic MODE_LOG = 1'b1;

  localparam logic [1:0] FMT_HALF   = 2'b00;
  localparam logic [1:0] FMT_SINGLE = 2'b01;
  localparam logic [1:0] FMT_DOUBLE = 2'b10;
  localparam logic [1:0] FMT_EXT    = 2'b11;

  localparam int STALL_W = 16;

endpackage

// File: rtl/bkm_lat_timer.sv
// Loadable down-counter that times the lut_decoder output latency.
// Ports:
//  clk, srst   : clock, synchronous active-high reset
//  i_load      : load i_load_val (has priority over i_dec)
//  i_load_val  : value to load
//  i_dec       : decrement by one; holds at zero
//  o_zero      : counter is zero
module bkm_lat_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bkm_lut_seq_ctrl.sv
// Iteration sequencer for the BKM FPU datapath. On start it walks the
// lut_decoder index n through 0..N_ITER-1; for each n it requests the LUT,
// waits LUT_LAT cycles, then presents dp_step to the X/Y/u/v datapath and
// holds it until dp_ready. A one-cycle done follows the last handshake.
// Ports:
//  clk, srst, enable       : clock, sync active-high reset, clock enable
//  start, abort            : begin (IDLE only) / cancel an operation
//  mode, format            : operation attributes, latched on accepted start
//  lut_req, lut_n          : LUT request strobe and iteration index
//  lut_mode, lut_format    : latched attributes
//  dp_step, dp_ready       : step handshake to the datapath
//  busy, done              : operation status
//  stall_cnt               : saturating count of dp_step && !dp_ready cycles
//  dbg_state               : current FSM state
//
// Handshake: a step transfers on a cycle where dp_step=1 and dp_ready=1 are
// both sampled at the clock edge (with enable=1); dp_step stays high and
// lut_n stays fixed until that happens.
module bkm_lut_seq_ctrl
  import bkm_pkg::*;
#(
  parameter int LOG2N   = 6,
  parameter int N_ITER  = 32,
  parameter int LUT_LAT = 2
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               enable,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [1:0]         format,
  output logic               lut_req,
  output logic [LOG2N-1:0]   lut_n,
  output logic               lut_mode,
  output logic [1:0]         lut_format,
  output logic               dp_step,
  input  logic               dp_ready,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt,
  output state_t             dbg_state
);

  // Timer width never drops below 1 so LUT_LAT=0 still elaborates.
  localparam int TW = (LUT_LAT < 1) ? 1 : $clog2(LUT_LAT + 1);
  localparam logic [TW-1:0] LOAD_VAL = (LUT_LAT > 0) ? TW'(LUT_LAT - 1) : '0;
  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N_ITER - 1);

  state_t               r_state;
  state_t               w_next;
  logic [LOG2N-1:0]     r_n;
  logic                 r_mode;
  logic [1:0]           r_format;
  logic [STALL_W-1:0]   r_stall;
  logic                 w_load;
  logic                 w_dec;
  logic                 w_zero;
  logic                 w_accept;
  logic                 w_hs;
  logic                 w_last;

  bkm_lat_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .srst       (srst),
    .i_load     (enable && w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (enable && w_dec),
    .o_zero     (w_zero)
  );

  assign w_last   = (r_n == N_LAST);
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_hs     = (r_state == ST_STEP) && dp_ready && !abort;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_load = 1'b1;
        w_next = (LUT_LAT == 0) ? ST_STEP : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_zero) w_next = ST_STEP;
        else        w_dec  = 1'b1;
      end
      ST_STEP: begin
        if (dp_ready) w_next = w_last ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // Abort overrides every non-IDLE transition; start wins in IDLE.
    if (abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state  <= ST_IDLE;
      r_n      <= '0;
      r_mode   <= 1'b0;
      r_format <= 2'b00;
      r_stall  <= '0;
    end else if (enable) begin
      r_state <= w_next;
      if (w_accept) begin
        r_n      <= '0;
        r_mode   <= mode;
        r_format <= format;
        r_stall  <= '0;
      end else begin
        if (dp_step && !dp_ready && (r_stall != '1)) r_stall <= r_stall + 1'b1;
        // Compare-before-increment: the last index never advances, so n
        // stays within 0..N_ITER-1.
        if (w_next == ST_IDLE)   r_n <= '0;
        else if (w_hs && !w_last) r_n <= r_n + 1'b1;
      end
    end
  end

  assign lut_req    = (r_state == ST_ISSUE);
  assign dp_step    = (r_state == ST_STEP);
  assign done       = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign lut_n      = r_n;
  assign lut_mode   = r_mode;
  assign lut_format = r_format;
  assign stall_cnt  = r_stall;
  assign dbg_state  = r_state;

endmodule
